// File: rtl/dti_fifo_rd_adapter_buf2.sv
// Two-entry in-order register buffer; head is always entry 0, so a pop shifts entry 1 down.
// Head output is registered; push is accepted when not full or when a pop frees a slot in the same cycle.
module dti_fifo_rd_adapter_buf2 #(
  parameter int DATA_WIDTH = 21
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_dat,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_dat,
  output logic [1:0]            count
);

  localparam int DEPTH = 2;

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pop_ok;
  logic                  push_ok;

  always_comb begin
    pop_ok  = pop && (cnt_q != 2'd0);
    push_ok = push && ((cnt_q != 2'(DEPTH)) || pop_ok);
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    cnt_d   = cnt_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          ent0_d = push_dat;
        end else begin
          ent1_d = push_dat;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        // Popping the last word leaves entry 0 untouched so the head holds its value.
        if (cnt_q == 2'(DEPTH)) begin
          ent0_d = ent1_q;
        end
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'(DEPTH)) begin
          ent0_d = ent1_q;
          ent1_d = push_dat;
        end else begin
          ent0_d = push_dat;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_dat = ent0_q;
  assign count    = cnt_q;

endmodule

// File: rtl/dti_fifo_rd_stream_adapter.sv
// Turns an async-FIFO read port (req, data next cycle) into a valid/ready stream; word latency is 2 edges after req.
// Requests are issued only while buffered plus in-flight words fit in the 2-entry buffer, so m_ready backpressure never overflows it.
module dti_fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 21
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  fifo_req,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_error,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  err_sticky,
  input  logic                  err_clr,
  output logic [1:0]            level
);

  localparam int BUF_DEPTH = 2;

  logic                  pending_q, pending_d;
  logic                  err_q, err_d;
  logic                  pop;
  logic                  capture;
  logic [1:0]            count;
  logic [2:0]            in_flight;
  logic [2:0]            room;
  logic [DATA_WIDTH-1:0] head_dat;

  always_comb begin
    pop       = m_valid && m_ready;
    capture   = pending_q && !fifo_error;
    in_flight = {1'b0, count} + {2'b00, pending_q};
    room      = 3'(BUF_DEPTH) + {2'b00, pop};
    // reset_n gating keeps the request low for the whole reset window, not just after the first edge.
    fifo_req  = reset_n && !fifo_empty && (in_flight < room);
    pending_d = fifo_req;
    err_d     = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (pending_q && fifo_error) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  dti_fifo_rd_adapter_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (capture),
    .push_dat (fifo_dout),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

  assign m_valid    = (count != 2'd0);
  assign m_data     = head_dat;
  assign level      = count;
  assign err_sticky = err_q;

endmodule

// File: doc/dti_fifo_rd_stream_adapter.md
DTI_FIFO_RD_STREAM_ADAPTER -- requirements
Module: dti_fifo_rd_stream_adapter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 21: width of data words in bits.
REQ-002 SHALL have port clk, input, 1: single clock, the async FIFO read clock.
REQ-003 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port fifo_req, output, 1: pop request to the async FIFO read side.
REQ-005 SHALL have port fifo_empty, input, 1: FIFO read-side empty status, reflecting pops up to the previous edge.
REQ-006 SHALL have port fifo_dout, input, DATA_WIDTH: FIFO read data, valid the cycle after fifo_req.
REQ-007 SHALL have port fifo_error, input, 1: FIFO reports that the previous-cycle read failed.
REQ-008 SHALL have port m_valid, output, 1: stream word available.
REQ-009 SHALL have port m_data, output, DATA_WIDTH: stream word, head of the buffer.
REQ-010 SHALL have port m_ready, input, 1: downstream accepts.
REQ-011 SHALL have port err_sticky, output, 1: a failed read has occurred since reset or the last clear.
REQ-012 SHALL have port err_clr, input, 1: synchronous clear of err_sticky.
REQ-013 SHALL have port level, output, 2: buffered word count, 0..2.

Function
REQ-014 SHALL hold a 2-entry in-order buffer (count 0..2) plus a 1-bit pending flag, set in the cycle after fifo_req is asserted.
REQ-015 SHALL compute pop = m_valid && m_ready.
REQ-016 SHALL drive fifo_req = !fifo_empty && (count + pending < 2 + pop); fifo_req is combinational from m_ready.
REQ-017 SHALL never assert fifo_req while fifo_empty=1.
REQ-018 When pending=1 and fifo_error=0, SHALL capture fifo_dout at the buffer tail on that edge.
REQ-019 When pending=1 and fifo_error=1, SHALL discard fifo_dout and set err_sticky; count is unchanged by the capture.
REQ-020 SHALL update count_next = count + (pending && !fifo_error) - pop; count SHALL never exceed 2 or underflow.
REQ-021 SHALL assert m_valid = (count != 0), registered, with m_data equal to the oldest stored word.
REQ-022 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0 (AXI-style: no retraction).
REQ-023 SHALL hold m_data at its last value while m_valid=0.
REQ-024 Latency: a word SHALL appear on m_valid two clk edges after the edge where fifo_req=1 sampled it (req edge, capture edge).
REQ-025 SHALL sustain 1 word/cycle when fifo_empty=0 and m_ready=1 continuously.
REQ-026 On a simultaneous capture and pop at count=2, SHALL shift the buffer and keep count=2 with order preserved.
REQ-027 On a simultaneous capture and pop at count=1, SHALL present the captured word as the new head.
REQ-028 If err_clr and a new error occur in the same cycle, the error SHALL win and err_sticky stays 1.
REQ-029 level SHALL equal count.

Reset
REQ-030 On reset_n=0, SHALL asynchronously force count=0, pending=0, m_valid=0, m_data=0, err_sticky=0 and level=0.
REQ-031 While reset_n=0, SHALL hold fifo_req=0.
REQ-032 Reset assertion mid-transfer SHALL drop in-flight and buffered words without producing any m_valid glitch.
REQ-033 After release, SHALL resume per REQ-016 on the first clk edge.

Structure
REQ-034 No shared package SHALL be required; buffer depth 2 SHALL be a localparam.
REQ-035 SHALL place the storage in one sub-module, dti_fifo_rd_adapter_buf2 (2-entry shift or ping-pong register buffer, with push, pop, head output and count).
REQ-036 The control (pending flag, fifo_req logic and error flag) SHALL live in the top module.

Verification
REQ-037 Scenario: reset, then fifo_empty=0 with words 0x1,0x2,0x3 and m_ready=1 -> m_valid first high at the 2nd edge after the first fifo_req; m_data 0x1,0x2,0x3 on consecutive cycles.
REQ-038 Scenario: fifo_empty=0 throughout with m_ready=0 -> exactly 2 fifo_req pulses, level=2, fifo_req=0 afterwards; m_ready=1 then drains in order with no loss.
REQ-039 Scenario: count=2 with fifo_req and m_ready toggling every cycle -> m_data sequence is strictly ordered, level never exceeds 2, no duplicate words.
REQ-040 Scenario: fifo_error=1 in the capture cycle of word 0x5 -> 0x5 is never presented, err_sticky=1 from the next cycle, following words continue; err_clr=1 -> err_sticky=0.
REQ-041 Scenario: reset_n pulsed low with level=2 and pending=1 -> m_valid=0 and level=0 immediately; no stale word appears after release.
REQ-042 Scenario: fifo_empty=1 for 10 cycles with m_ready=1 -> fifo_req stays 0 and m_valid stays 0.
